// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FPU types and constants
package fpnew_pkg;
  localparam int unsigned NUM_FP_FORMATS = 5;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

// File: rtl/fpnew_rr_arbiter.sv
// fpnew_rr_arbiter: round-robin grant whose pointer moves past each taken grant
//   clk, rst    clock, async active-high reset (pointer -> 0)
//   req         per-requester request
//   advance     grant taken this cycle; pointer becomes gnt_idx+1 (wrapping)
//   gnt_onehot  one-hot winner (zero when no request)
//   gnt_idx     winner index
module fpnew_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);
  if (N == 1) begin : g_single
    logic unused;
    assign unused = ^{clk, rst, advance};
    assign gnt_onehot = req;
    assign gnt_idx = '0;
  end else begin : g_rr
    logic [IW-1:0] ptr;
    // scan downward so the last hit, i.e. the one closest above ptr, wins
    always_comb begin
      gnt_onehot = '0;
      gnt_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          gnt_onehot = N'(1) << ((int'(ptr) + k) % N);
          gnt_idx = IW'((int'(ptr) + k) % N);
        end
      end
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (advance) ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/fpnew_opgroup_out_arbiter.sv
// fpnew_opgroup_out_arbiter: round-robin merge of per-format results into one output register
//   clk_i, rst_i                 clock, async active-high reset
//   in_*_i / in_valid_i          per-slice result, status, ext bit, tag and valid
//   in_ready_o                   one-hot accept of the granted slice (zero when stalled/flushed)
//   flush_i                      drop the held result and accept nothing this cycle
//   result_o .. src_idx_o        registered output payload and producing slice
//   out_valid_o, out_ready_i     output handshake; busy_o mirrors out_valid_o
module fpnew_opgroup_out_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumInputs = NUM_FP_FORMATS,
  parameter int unsigned Width = 32,
  parameter type TagType = logic,
  localparam int unsigned IdxW = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumInputs-1:0][Width-1:0]     in_result_i,
  input  status_t [NumInputs-1:0]             in_status_i,
  input  logic [NumInputs-1:0]                in_ext_bit_i,
  input  TagType [NumInputs-1:0]              in_tag_i,
  input  logic [NumInputs-1:0]                in_valid_i,
  output logic [NumInputs-1:0]                in_ready_o,
  input  logic                                flush_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output logic                                extension_bit_o,
  output TagType                              tag_o,
  output logic [IdxW-1:0]                     src_idx_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o
);
  logic out_valid_q, accept, push;
  logic [NumInputs-1:0] gnt;
  logic [IdxW-1:0] win;
  fpnew_rr_arbiter #(.N(NumInputs)) i_arb (
    .clk(clk_i),
    .rst(rst_i),
    .req(in_valid_i),
    .advance(push),
    .gnt_onehot(gnt),
    .gnt_idx(win)
  );
  // reset is folded in so slices never see a ready while the stage is held in reset
  assign accept = (~out_valid_q | out_ready_i) & ~flush_i & ~rst_i;
  assign in_ready_o = accept ? ((NumInputs == 1) ? '1 : gnt) : '0;
  assign push = accept & |in_valid_i;
  assign out_valid_o = out_valid_q;
  assign busy_o = out_valid_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      out_valid_q <= 1'b0;
      result_o <= '0;
      status_o <= '0;
      extension_bit_o <= 1'b0;
      tag_o <= '0;
      src_idx_o <= '0;
    end else begin
      out_valid_q <= push | (out_valid_q & ~out_ready_i & ~flush_i);
      if (push) begin
        result_o <= in_result_i[win];
        status_o <= in_status_i[win];
        extension_bit_o <= in_ext_bit_i[win];
        tag_o <= in_tag_i[win];
        src_idx_o <= win;
      end
    end
endmodule

// File: tb/tb_fpnew_opgroup_out_arbiter.sv
// tb_fpnew_opgroup_out_arbiter: directed and random checks against a behavioural model
module tb_fpnew_opgroup_out_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0][31:0] in_result;
  logic [N-1:0][4:0] in_status;
  logic [N-1:0] in_ext, in_valid, in_ready;
  logic [N-1:0][3:0] in_tag;
  logic flush = 1'b0, out_ready = 1'b0, out_valid, busy, ext_o;
  logic [31:0] result_o;
  logic [4:0] status_o;
  logic [3:0] tag_o;
  logic [1:0] src_o;
  int n_chk = 0, n_pass = 0;
  int m_p, m_src, h;
  bit m_valid;
  logic [31:0] m_res;
  logic [4:0] m_st;
  logic [3:0] m_tag;
  logic m_ext;
  int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
  always #5 clk = ~clk;
  fpnew_opgroup_out_arbiter #(.NumInputs(N), .Width(32), .TagType(logic [3:0])) dut (
    .clk_i(clk), .rst_i(rst_i), .in_result_i(in_result), .in_status_i(in_status),
    .in_ext_bit_i(in_ext), .in_tag_i(in_tag), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .result_o(result_o), .status_o(status_o), .extension_bit_o(ext_o),
    .tag_o(tag_o), .src_idx_o(src_o), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic model_reset();
    m_p = 0; m_valid = 0; m_res = '0; m_st = '0; m_tag = '0; m_ext = 1'b0; m_src = 0;
  endtask
  task automatic rnd_data();
    for (int i = 0; i < N; i++) begin
      in_result[i] = $urandom;
      in_status[i] = 5'($urandom_range(0, 31));
      in_ext[i] = 1'($urandom_range(0, 1));
      in_tag[i] = 4'($urandom_range(0, 15));
    end
  endtask
  task automatic tick();
    int w;
    logic [N-1:0] er;
    #1;
    w = pick(in_valid, m_p);
    er = '0;
    if (!rst_i && (!m_valid || out_ready) && !flush && w >= 0) er[w] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid));
    chk("result", result_o, m_res);
    chk("status", 32'(status_o), 32'(m_st));
    chk("ext", 32'(ext_o), 32'(m_ext));
    chk("tag", 32'(tag_o), 32'(m_tag));
    chk("src", 32'(src_o), 32'(m_src));
    @(posedge clk);
    if (rst_i) model_reset();
    else if (er != '0) begin
      m_valid = 1; m_res = in_result[w]; m_st = in_status[w]; m_ext = in_ext[w];
      m_tag = in_tag[w]; m_src = w; m_p = (w + 1) % N;
    end else if (flush || out_ready) m_valid = 0;
    #2;
  endtask
  initial begin
    model_reset();
    in_valid = 3'($urandom_range(0, 7));
    rnd_data();
    tick();
    in_valid = 3'b111;
    rnd_data();
    tick();
    rst_i = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rnd_data();
      tick();
      chk("seq_src", 32'(src_o), exp_seq[k]);
      chk("seq_valid", 32'(out_valid), 1);
    end
    in_valid = 3'b010;
    rnd_data();
    in_result[1] = 32'h3F80_0000;
    in_status[1] = 5'b00001;
    in_tag[1] = 4'd5;
    tick();
    chk("one_result", result_o, 32'h3F80_0000);
    chk("one_status", 32'(status_o), 1);
    chk("one_tag", 32'(tag_o), 5);
    chk("one_src", 32'(src_o), 1);
    in_valid = 3'b111;
    rnd_data();
    tick();
    chk("ptr_after_one", 32'(src_o), 2);
    h = m_src;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      tick();
      chk("hold_src", 32'(src_o), h);
      chk("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("release_src", 32'(src_o), (h + 1) % N);
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 3'b100;
    rnd_data();
    tick();
    chk("flush_drop", 32'(out_valid), 0);
    flush = 1'b0;
    tick();
    chk("post_flush_valid", 32'(out_valid), 1);
    chk("post_flush_src", 32'(src_o), 2);
    out_ready = 1'b1;
    in_valid = 3'b010;
    tick();
    in_valid = 3'b111;
    out_ready = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("rst_ready", 32'(in_ready), 0);
    model_reset();
    tick();
    rst_i = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_src", 32'(src_o), 0);
    for (int k = 0; k < 400; k++) begin
      in_valid = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      rnd_data();
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
